// File: rtl/choice_capture.sv
// choice_capture
//   Two-player choice entry. Each player sets the one-hot choice switches
//   and presses the commit button. The button is synchronized and debounced,
//   and each debounced press captures one choice. Once both choices are
//   captured the pair is presented until the controller acknowledges it.
//
// Ports
//   clk            system clock, the only clock used
//   reset          synchronous, active-high reset
//   sw[2:0]        raw choice switches, one-hot (001 cat, 010 dog, 100 chicken)
//   key_n          raw commit button, active-low, asynchronous, bouncing
//   scenario_ack   controller has consumed the presented pair (level)
//   player1_choice captured player 1 choice
//   player2_choice captured player 2 choice
//   choice_valid   pair is being presented
//   waiting_p1     waiting for player 1 commit
//   waiting_p2     waiting for player 2 commit
//   invalid_flag   one-cycle pulse when a commit had a non-one-hot choice
module choice_capture #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] sw,
  input  logic       key_n,
  input  logic       scenario_ack,
  output logic [2:0] player1_choice,
  output logic [2:0] player2_choice,
  output logic       choice_valid,
  output logic       waiting_p1,
  output logic       waiting_p2,
  output logic       invalid_flag
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // One-hot encoding so each status output is a state flop bit.
  localparam logic [2:0] WAIT_P1 = 3'b001;
  localparam logic [2:0] WAIT_P2 = 3'b010;
  localparam logic [2:0] PRESENT = 3'b100;

  logic          key_s1, key_s2;
  logic [2:0]    sw_s1, sw_s2;
  logic          key_deb;
  logic [CW-1:0] cnt;
  logic          press;
  logic [2:0]    state;
  logic          sw_ok;

  // Two-flop synchronizers; the key resets to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
      sw_s1  <= 3'b000;
      sw_s2  <= 3'b000;
    end else begin
      key_s1 <= key_n;
      key_s2 <= key_s1;
      sw_s1  <= sw;
      sw_s2  <= sw_s1;
    end
  end

  // Debounce: count consecutive cycles where the synchronized key disagrees
  // with the accepted level; the final disagreeing cycle flips the level.
  // The counter stops at CNT_LAST, so it can never wrap. A registered press
  // pulse is raised on the 1->0 flip only.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_deb <= 1'b1;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_s2 == key_deb) begin
        cnt <= '0;
      end else if (cnt >= CNT_LAST) begin
        key_deb <= key_s2;
        cnt     <= '0;
        press   <= ~key_s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_comb begin
    sw_ok = (sw_s2 == 3'b001) || (sw_s2 == 3'b010) || (sw_s2 == 3'b100);
  end

  // Choice FSM. In PRESENT, presses are dropped and ack takes priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= WAIT_P1;
      player1_choice <= 3'b001;
      player2_choice <= 3'b001;
      invalid_flag   <= 1'b0;
    end else begin
      invalid_flag <= 1'b0;
      case (state)
        WAIT_P1: begin
          if (press) begin
            if (sw_ok) begin
              player1_choice <= sw_s2;
              state          <= WAIT_P2;
            end else begin
              invalid_flag <= 1'b1;
            end
          end
        end
        WAIT_P2: begin
          if (press) begin
            if (sw_ok) begin
              player2_choice <= sw_s2;
              state          <= PRESENT;
            end else begin
              invalid_flag <= 1'b1;
            end
          end
        end
        PRESENT: begin
          if (scenario_ack) state <= WAIT_P1;
        end
        default: state <= WAIT_P1;
      endcase
    end
  end

  assign waiting_p1   = state[0];
  assign waiting_p2   = state[1];
  assign choice_valid = state[2];

endmodule

// File: tb/tb_choice_capture.sv
module tb_choice_capture;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] sw;
  logic       key_n;
  logic       scenario_ack;
  logic [2:0] player1_choice, player2_choice;
  logic       choice_valid, waiting_p1, waiting_p2, invalid_flag;

  int tests = 0;
  int fails = 0;
  int inv_count = 0;

  choice_capture #(.DEBOUNCE_CYCLES(N)) dut (
    .clk(clk), .reset(reset), .sw(sw), .key_n(key_n),
    .scenario_ack(scenario_ack),
    .player1_choice(player1_choice), .player2_choice(player2_choice),
    .choice_valid(choice_valid), .waiting_p1(waiting_p1),
    .waiting_p2(waiting_p2), .invalid_flag(invalid_flag)
  );

  always #5 clk = ~clk;

  // Behavioural model. kh[k]/sh[k] hold the raw input sampled k+1 edges ago
  // (synchronizer flops are forced to released/zero by reset). The accepted
  // key level flips when the N most recent synchronized samples all differ
  // from it; a 1->0 flip is a press seen by the choice logic one edge later.
  logic       kh [0:N];
  logic [2:0] sh [0:1];
  logic       m_deb, m_press, m_inv, m_ready = 1'b0;
  int         m_state;
  logic [2:0] m_p1, m_p2;

  function automatic logic one_hot(input logic [2:0] v);
    return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k <= N; k++) kh[k] = 1'b1;
      sh[0] = 3'b000; sh[1] = 3'b000;
      m_deb = 1'b1; m_press = 1'b0; m_inv = 1'b0;
      m_state = 0; m_p1 = 3'b001; m_p2 = 3'b001;
      m_ready = 1'b1;
    end else if (m_ready) begin
      logic all_diff;
      logic np;
      m_inv = 1'b0;
      if (m_press && m_state != 2) begin
        if (!one_hot(sh[1])) m_inv = 1'b1;
        else if (m_state == 0) begin m_p1 = sh[1]; m_state = 1; end
        else begin m_p2 = sh[1]; m_state = 2; end
      end else if (m_state == 2 && scenario_ack) begin
        m_state = 0;
      end
      all_diff = 1'b1;
      for (int k = 1; k <= N; k++) if (kh[k] == m_deb) all_diff = 1'b0;
      np = all_diff && m_deb;
      if (all_diff) m_deb = ~m_deb;
      m_press = np;
      for (int k = N; k > 0; k--) kh[k] = kh[k-1];
      kh[0] = key_n;
      sh[1] = sh[0]; sh[0] = sw;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: every cycle once the model has seen a reset.
  always @(negedge clk) begin
    if (invalid_flag) inv_count++;
    if (m_ready) begin
      check("p1_choice", int'(player1_choice), int'(m_p1));
      check("p2_choice", int'(player2_choice), int'(m_p2));
      check("waiting_p1", int'(waiting_p1), int'(m_state == 0));
      check("waiting_p2", int'(waiting_p2), int'(m_state == 1));
      check("choice_valid", int'(choice_valid), int'(m_state == 2));
      check("invalid_flag", int'(invalid_flag), int'(m_inv));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    cycles(2);
    reset = 1'b0;
  endtask

  // Press with choice v, hold low for `hold` cycles, then release and settle.
  task automatic press(input logic [2:0] v, input int hold);
    @(negedge clk);
    sw = v; key_n = 1'b0;
    cycles(hold);
    key_n = 1'b1;
    cycles(N + 6);
  endtask

  initial begin
    reset = 1'b1; sw = 3'b001; key_n = 1'b1; scenario_ack = 1'b0;
    cycles(3);
    reset = 1'b0;
    // Reset values.
    check("rst_p1", int'(player1_choice), 1);
    check("rst_p2", int'(player2_choice), 1);
    check("rst_wait1", int'(waiting_p1), 1);
    check("rst_valid", int'(choice_valid), 0);
    check("rst_inv", int'(invalid_flag), 0);

    // Exact latency: captured at edge N+3 = 7, not at edge 6.
    inv_count = 0;
    sw = 3'b010; key_n = 1'b0;
    repeat (6) @(posedge clk);
    #1 check("lat_edge6_wait1", int'(waiting_p1), 1);
    @(posedge clk);
    #1 check("lat_edge7_p1", int'(player1_choice), 2);
    check("lat_edge7_wait2", int'(waiting_p2), 1);
    cycles(14);
    check("held_no_change", int'(waiting_p2), 1);
    check("held_no_inv", inv_count, 0);
    key_n = 1'b1;
    cycles(N + 6);

    // P2 commit, then a press while presenting is discarded.
    press(3'b100, 8);
    check("present_valid", int'(choice_valid), 1);
    check("present_pair", int'({player1_choice, player2_choice}), 6'b010_100);
    press(3'b001, 8);
    check("present_ignore", int'({choice_valid, player2_choice}), 4'b1_100);
    @(negedge clk); scenario_ack = 1'b1;
    @(negedge clk); scenario_ack = 1'b0;
    check("ack_wait1", int'(waiting_p1), 1);
    check("ack_hold_p1", int'(player1_choice), 2);

    // Glitchy key: no run of N stable low cycles.
    do_reset();
    key_n = 1'b0; cycles(3); key_n = 1'b1; cycles(1);
    key_n = 1'b0; cycles(3); key_n = 1'b1; cycles(N + 6);
    check("glitch_wait1", int'(waiting_p1), 1);

    // Non-one-hot commit in WAIT_P1.
    inv_count = 0;
    press(3'b011, 10);
    check("inv_once", inv_count, 1);
    check("inv_p1", int'(player1_choice), 1);
    check("inv_wait1", int'(waiting_p1), 1);

    // Ack and press event in the same PRESENT cycle: ack wins.
    press(3'b100, 8);
    press(3'b010, 8);
    check("pre_ack_valid", int'(choice_valid), 1);
    @(negedge clk);
    sw = 3'b001; key_n = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk); scenario_ack = 1'b1;
    @(posedge clk);
    #1 check("ackwin_wait1", int'(waiting_p1), 1);
    check("ackwin_valid", int'(choice_valid), 0);
    check("ackwin_p1", int'(player1_choice), 4);
    @(negedge clk); scenario_ack = 1'b0;
    cycles(6); key_n = 1'b1; cycles(N + 6);
    check("ackwin_still_wait1", int'(waiting_p1), 1);

    // Reset during WAIT_P2, two cycles into a debounce.
    press(3'b100, 8);
    check("pre_rst_wait2", int'(waiting_p2), 1);
    @(negedge clk); sw = 3'b010; key_n = 1'b0;
    cycles(4);
    reset = 1'b1; cycles(1); reset = 1'b0;
    check("midrst_wait1", int'(waiting_p1), 1);
    check("midrst_pair", int'({player1_choice, player2_choice}), 6'b001_001);
    check("midrst_cnt", int'(dut.cnt), 0);
    // Key still held through reset release: exactly one press follows.
    cycles(20); key_n = 1'b1; cycles(N + 6);
    check("held_thru_rst", int'({waiting_p2, player1_choice}), 4'b1_010);

    // Randomized phase; the compare process checks every cycle.
    begin
      int run = 0;
      for (int i = 0; i < 4000; i++) begin
        @(negedge clk);
        if (run == 0) begin
          key_n = 1'($urandom_range(0, 1));
          run = $urandom_range(1, 9);
          if ($urandom_range(0, 2) == 0) sw = 3'($urandom_range(0, 7));
          else sw = 3'(1 << $urandom_range(0, 2));
        end
        run--;
        scenario_ack = ($urandom_range(0, 7) == 0);
        reset = ($urandom_range(0, 499) == 0);
      end
      reset = 1'b0; scenario_ack = 1'b0;
      cycles(2);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
